// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match sequencer.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ARM,
    SERVE,
    RALLY,
    POINT,
    GAME_OVER
  } ctrl_state_t;

  localparam int unsigned X_MAX   = 319;
  localparam int unsigned Y_MAX   = 239;
  localparam int unsigned SCORE_W = 4;

  // Saturating score increment; a score register can never wrap past all-ones.
  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    return (s == {SCORE_W{1'b1}}) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/pong_match_ctrl_cycle_timer.sv
// Free-running cycle counter with synchronous clear (priority) and count enable.
module cycle_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer: drives physics reset/launch, keeps score, times pauses and
// forces a re-serve when the ball stops moving horizontally.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned LEFT_LIMIT   = 0,
  parameter int unsigned RIGHT_LIMIT  = X_MAX,
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_DELAY  = 25_000_000,
  parameter int unsigned POINT_DELAY  = 50_000_000,
  parameter int unsigned STALL_CYCLES = 100_000_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [8:0]         ball_x,
  input  logic               ball_set,
  output logic               phys_reset_n,
  output logic               phys_go,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over,
  output logic               rally
);

  localparam int unsigned MAX_DELAY = (SERVE_DELAY > POINT_DELAY) ? SERVE_DELAY : POINT_DELAY;
  localparam int unsigned TIMER_W   = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam int unsigned STALL_W   = $clog2(STALL_CYCLES + 1);

  localparam logic [TIMER_W-1:0] SERVE_LAST = TIMER_W'(SERVE_DELAY - 1);
  localparam logic [TIMER_W-1:0] POINT_LAST = TIMER_W'(POINT_DELAY - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);
  localparam logic [8:0]         LEFT_X     = 9'(LEFT_LIMIT);
  localparam logic [8:0]         RIGHT_X    = 9'(RIGHT_LIMIT);
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

  ctrl_state_t        state_q, state_d;
  logic               start_q;
  logic [8:0]         ball_x_q;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic               serve_dir_q, serve_dir_d;

  logic               start_edge;
  logic               ball_moved;
  logic               stalled;
  logic               timer_clear, timer_en;
  logic [TIMER_W-1:0] timer_count;
  logic               stall_clear;
  logic [STALL_W-1:0] stall_count;

  assign start_edge = start & ~start_q;
  assign ball_moved = (ball_x != ball_x_q);
  // The STALL_CYCLES-th consecutive unchanged RALLY cycle triggers the re-serve.
  assign stalled    = !ball_moved && (stall_count == STALL_LAST);
  assign stall_clear = (state_q != RALLY) || ball_moved;

  cycle_timer #(
    .WIDTH (TIMER_W)
  ) u_phase_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .count  (timer_count)
  );

  cycle_timer #(
    .WIDTH (STALL_W)
  ) u_stall_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (stall_clear),
    .enable (1'b1),
    .count  (stall_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      ball_x_q    <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      serve_dir_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      ball_x_q    <= ball_x;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      serve_dir_q <= serve_dir_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    serve_dir_d  = serve_dir_q;
    phys_reset_n = 1'b0;
    phys_go      = 1'b0;
    game_over    = 1'b0;
    rally        = 1'b0;
    timer_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          score_l_d   = '0;
          score_r_d   = '0;
          serve_dir_d = 1'b1;
          state_d     = CLEAR;
        end
      end
      CLEAR: begin
        state_d = ARM;
      end
      ARM: begin
        phys_reset_n = 1'b1;
        timer_en     = ball_set;
        if (ball_set && (timer_count == SERVE_LAST)) begin
          state_d = SERVE;
        end
      end
      SERVE: begin
        phys_reset_n = 1'b1;
        phys_go      = 1'b1;
        state_d      = RALLY;
      end
      RALLY: begin
        phys_reset_n = 1'b1;
        rally        = 1'b1;
        if (ball_x <= LEFT_X) begin
          score_r_d   = score_inc(score_r_q);
          serve_dir_d = 1'b0;
          state_d     = POINT;
        end else if (ball_x >= RIGHT_X) begin
          score_l_d   = score_inc(score_l_q);
          serve_dir_d = 1'b1;
          state_d     = POINT;
        end else if (stalled) begin
          state_d = CLEAR;
        end
      end
      POINT: begin
        phys_reset_n = 1'b1;
        timer_en     = 1'b1;
        if (timer_count == POINT_LAST) begin
          state_d = ((score_l_q == WIN) || (score_r_q == WIN)) ? GAME_OVER : CLEAR;
        end
      end
      GAME_OVER: begin
        game_over = 1'b1;
        if (start_edge) begin
          score_l_d   = '0;
          score_r_d   = '0;
          serve_dir_d = 1'b1;
          state_d     = CLEAR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Serve hold only accumulates while the ball stays parked.
  assign timer_clear = (state_d != state_q) || ((state_q == ARM) && !ball_set);

  assign serve_dir = serve_dir_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;

endmodule
